// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with double-buffered duty registers, shared prescaler and readback
module pwm_bank #(
    parameter int NUM_CHANNELS = 8,
    parameter int DUTY_WIDTH = 8,
    localparam int ADDR_WIDTH = $clog2(NUM_CHANNELS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DUTY_WIDTH-1:0]   wr_data,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DUTY_WIDTH-1:0]   rd_data,
    input  logic                    sync_load,
    output logic [NUM_CHANNELS-1:0] pwm_out,
    output logic                    period_start
);
    localparam logic [DUTY_WIDTH-1:0] MAX = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] PRESC_ADDR = ADDR_WIDTH'(NUM_CHANNELS);
    logic [DUTY_WIDTH-1:0] shadow [NUM_CHANNELS];
    logic [DUTY_WIDTH-1:0] active [NUM_CHANNELS];
    logic [DUTY_WIDTH-1:0] presc_shadow, presc_active, presc_cnt, cnt, rd_mux;
    logic tick, wrap, load;
    assign tick = presc_cnt == presc_active;
    assign wrap = tick && cnt == MAX;
    assign load = sync_load || wrap;
    // Register-bank writes land only in the shadow copies; out-of-map addresses are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) shadow[i] <= '0;
            presc_shadow <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++)
                if (wr_en && wr_addr == ADDR_WIDTH'(i)) shadow[i] <= wr_data;
            if (wr_en && wr_addr == PRESC_ADDR) presc_shadow <= wr_data;
        end
    end
    // Shadows move to active only at a period boundary or on sync_load, so duty never changes mid-period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) active[i] <= '0;
            presc_active <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_CHANNELS; i++) active[i] <= shadow[i];
            presc_active <= presc_shadow;
        end
    end
    // Prescaler and period counter; the counter stops one short of all-ones so full duty stays high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
            cnt <= '0;
        end else begin
            presc_cnt <= (sync_load || tick) ? '0 : presc_cnt + 1'b1;
            cnt <= sync_load ? '0 : !tick ? cnt : (cnt == MAX) ? '0 : cnt + 1'b1;
        end
    end
    // Outputs compare against the current count, one cycle behind it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= '0;
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) pwm_out[i] <= cnt < active[i];
            period_start <= load;
        end
    end
    // Readback mux over the shadow map; unmapped addresses read as zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (rd_addr == ADDR_WIDTH'(i)) rd_mux = shadow[i];
        if (rd_addr == PRESC_ADDR) rd_mux = presc_shadow;
    end
    // Registered readback, independent of same-cycle writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: randomized scoreboard bench for pwm_bank against a period-arithmetic model
module tb_pwm_bank;
    localparam int N = 8;
    localparam int W = 8;
    localparam int A = 4;
    localparam int STEPS = (1 << W) - 1;

    typedef struct packed {
        logic [N-1:0] pwm;
        logic         ps;
        logic [W-1:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_en = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic [A-1:0] rd_addr = '0;
    logic [W-1:0] rd_data;
    logic sync_load = 1'b0;
    logic [N-1:0] pwm_out;
    logic period_start;

    int vectors = 0;
    int miscompares = 0;

    exp_t q[$];
    int m_sh[N];
    int m_act[N];
    int m_psh, m_p, m_k;

    pwm_bank dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .sync_load(sync_load),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    function automatic int period_len(input int p);
        return STEPS * (p + 1);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_sh[i] = 0;
            m_act[i] = 0;
        end
        m_psh = 0;
        m_p = 0;
        m_k = 0;
    endfunction

    // Reference model: position m_k counts clocks into the current period; the
    // tick count is m_k/(p+1) and the period ends after STEPS*(p+1) clocks.
    always @(posedge clk) begin
        exp_t e;
        int ticks;
        if (!reset) begin
            ticks = m_k / (m_p + 1);
            for (int i = 0; i < N; i++) e.pwm[i] = ticks < m_act[i];
            e.rd = (int'(rd_addr) < N) ? W'(m_sh[rd_addr]) : (int'(rd_addr) == N) ? W'(m_psh) : '0;
            if (sync_load || m_k + 1 == period_len(m_p)) begin
                for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
                m_p = m_psh;
                m_k = 0;
                e.ps = 1'b1;
            end else begin
                m_k = m_k + 1;
                e.ps = 1'b0;
            end
            if (wr_en && int'(wr_addr) < N) m_sh[wr_addr] = int'(wr_data);
            else if (wr_en && int'(wr_addr) == N) m_psh = int'(wr_data);
            q.push_back(e);
        end
    end

    // Monitor: every cycle presents one output triple; pop and compare
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (pwm_out !== e.pwm) begin
                miscompares++;
                $display("FAIL pwm_out t=%0t got=%h want=%h", $time, pwm_out, e.pwm);
            end
            vectors++;
            if (period_start !== e.ps) begin
                miscompares++;
                $display("FAIL period_start t=%0t got=%b want=%b", $time, period_start, e.ps);
            end
            vectors++;
            if (rd_data !== e.rd) begin
                miscompares++;
                $display("FAIL rd_data t=%0t addr=%0d got=%h want=%h", $time, rd_addr, rd_data, e.rd);
            end
        end
    end

    task automatic cyc(input logic we, input int wa, input int wd, input int ra, input logic sl);
        @(posedge clk);
        #1;
        wr_en = we;
        wr_addr = A'(wa);
        wr_data = W'(wd);
        rd_addr = A'(ra);
        sync_load = sl;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, $urandom_range(0, 15), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        wr_en = 1'b0;
        sync_load = 1'b0;
        #1;
        vectors++;
        if (pwm_out !== '0 || period_start !== 1'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset got pwm=%h ps=%b rd=%h want 0/0/0", pwm_out, period_start, rd_data);
        end
        model_clear();
        q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit hit;
        model_clear();
        do_reset();
        // 1: duty 0x80 takes effect only at the first natural wrap
        cyc(1'b1, 0, 8'h80, 0, 1'b0);
        run(800);
        // 2: duty 0 and full duty after sync_load
        cyc(1'b1, 1, 8'h00, 1, 1'b0);
        cyc(1'b1, 2, 8'hFF, 2, 1'b0);
        cyc(1'b0, 0, 0, 2, 1'b1);
        run(300);
        // 3: prescaler 3, duty 0x40
        cyc(1'b1, 8, 3, 8, 1'b0);
        cyc(1'b1, 0, 8'h40, 0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        run(2200);
        // 4: write exactly in the wrap cycle uses the old shadow for that transfer
        cyc(1'b1, 8, 0, 8, 1'b0);
        cyc(1'b1, 0, 8'h10, 0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        run(1);
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (m_k == period_len(m_p) - 1) hit = 1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL wrap_search got=timeout want=wrap_cycle");
        end
        wr_en = 1'b1;
        wr_addr = 0;
        wr_data = 8'h20;
        run(600);
        // 5: out-of-map write ignored; readback map
        cyc(1'b1, 3, 8'h3C, 0, 1'b0);
        cyc(1'b1, 9, 8'h55, 8, 1'b0);
        cyc(1'b0, 0, 0, 9, 1'b0);
        cyc(1'b0, 0, 0, 3, 1'b0);
        for (int a = 0; a < 16; a++) cyc(1'b0, 0, 0, a, 1'b0);
        // random traffic
        for (int i = 0; i < 6000; i++) begin
            int wa;
            wa = $urandom_range(0, 15);
            cyc(($urandom_range(0, 7) == 0), wa,
                (wa == N) ? $urandom_range(0, 2) : $urandom_range(0, 255),
                $urandom_range(0, 15), ($urandom_range(0, 599) == 0));
        end
        run(10);
        // 6: async reset mid-period with all outputs high
        for (int c = 0; c < N; c++) cyc(1'b1, c, 8'hFF, c, 1'b0);
        cyc(1'b1, 8, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        run(40);
        do_reset();
        for (int a = 0; a < 10; a++) cyc(1'b0, 0, 0, a, 1'b0);
        run(300);
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
